error_sweep_ctrl: RTL and testbench

Sequencer that drives the single-bit error injector's `selectt` input and checks the ECC decoder's output, sweeping every injectable data-bit position plus one error-free vector. It sits upstream of the encoder and error injector: it supplies the data word and the error position, then consumes the decoder's corrected data and scores each vector. Used for self-test of the 64-bit encoder/decoder chain and in simulation regressions.

---
 rtl/ecc_test_pkg.sv | 38 +++
 rtl/error_sweep_ctrl_if.sv | 36 +++
 rtl/error_sweep_ctrl_wait_timer.sv | 36 +++
 rtl/error_sweep_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_error_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_test_pkg.sv
// Shared definitions for the ECC encoder/decoder self-test chain: sweep
// state encoding, select/result constants and the default chain widths.
package ecc_test_pkg;

   localparam int unsigned DEF_DATA_W  = 64;
   localparam int unsigned DEF_SEL_W   = 64;
   localparam int unsigned DEF_NUM_POS = 64;
   localparam int unsigned DEF_TIMEOUT = 16;

   // Vector index / result counter width (NUM_POS+1 vectors fit in 7 bits)
   localparam int unsigned POS_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_e;

   // All-ones select: the injector passes the word through untouched
   localparam logic [DEF_SEL_W-1:0] NO_ERR_SEL = '1;

   localparam logic [POS_W-1:0] FIRST_FAIL_NONE = 7'h7F;

   // Per-sweep scoreboard, held until the next accepted start
   typedef struct packed {
      logic [POS_W-1:0] fail_cnt;
      logic [POS_W-1:0] first_fail_pos;
      logic             timeout_err;
   } sweep_result_t;

   localparam sweep_result_t RESULT_CLEAR = '{
      fail_cnt:       '0,
      first_fail_pos: FIRST_FAIL_NONE,
      timeout_err:    1'b0
   };

endpackage

// File: rtl/error_sweep_ctrl_if.sv
// Encoder-side and decoder-side bus between the sweep controller and the
// encoder / error-injector / decoder chain.
//   enc_data, enc_valid : word and one-cycle strobe to the encoder
//   selectt             : error position for the injector
//   dec_valid, dec_data : corrected word back from the decoder
// master = sweep controller, slave = ECC chain.
interface error_sweep_ctrl_if
   import ecc_test_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned SEL_W  = DEF_SEL_W
);

   logic [DATA_W-1:0] enc_data;
   logic              enc_valid;
   logic [SEL_W-1:0]  selectt;
   logic              dec_valid;
   logic [DATA_W-1:0] dec_data;

   modport master (
      output enc_data,
      output enc_valid,
      output selectt,
      input  dec_valid,
      input  dec_data
   );

   modport slave (
      input  enc_data,
      input  enc_valid,
      input  selectt,
      output dec_valid,
      output dec_data
   );

endinterface

// File: rtl/error_sweep_ctrl_wait_timer.sv
// WAIT-state cycle counter with synchronous clear and count enable.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (takes priority over en)
//   en         : count one cycle
//   tc_c       : high during the TIMEOUT-th enabled cycle since clear
module wait_timer
   import ecc_test_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;

   // Saturates at the terminal count; the owner leaves WAIT on tc_c anyway
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc_c) begin
         cnt <= CNT_W'(cnt + 1'b1);
      end
   end

   // Count of TIMEOUT-1 means this is the TIMEOUT-th WAIT cycle
   assign tc_c = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/error_sweep_ctrl.sv
// Single-bit error sweep sequencer for the ECC encoder/decoder chain.
// Issues NUM_POS vectors with the error injected at positions 0..NUM_POS-1
// plus one error-free vector, and scores each decoder response.
//   clk, rst_n      : clock, async active-low reset
//   start           : level, accepted only in IDLE
//   data_seed       : base data word, latched on the accepted start
//   bus (master)    : enc_data/enc_valid/selectt out, dec_valid/dec_data in
//   busy            : high from ISSUE of vector 0 through DONE
//   done            : one-cycle pulse at sweep end
//   fail_cnt        : failing vectors in the last sweep
//   first_fail_pos  : index of the first failing vector, 7'h7F if none
//   timeout_err     : sticky, some vector got no dec_valid in time
module error_sweep_ctrl
   import ecc_test_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned SEL_W   = DEF_SEL_W,
   parameter int unsigned NUM_POS = DEF_NUM_POS,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     data_seed,
   error_sweep_ctrl_if.master    bus,
   output logic                  busy,
   output logic                  done,
   output logic [POS_W-1:0]      fail_cnt,
   output logic [POS_W-1:0]      first_fail_pos,
   output logic                  timeout_err
);

   sweep_state_e      state, state_nxt;
   logic [POS_W-1:0]  pos, pos_nxt;
   logic [DATA_W-1:0] seed, seed_nxt;
   logic [DATA_W-1:0] expected, expected_nxt;
   logic [DATA_W-1:0] enc_data_q, enc_data_nxt;
   logic              enc_valid_q, enc_valid_nxt;
   logic [SEL_W-1:0]  sel_q, sel_nxt;
   logic              busy_q, busy_nxt;
   logic              done_q, done_nxt;
   sweep_result_t     res_q, res_nxt;

   logic              tmr_clr, tmr_en, tmr_tc_c;
   logic              issue, vec_end, vec_fail;
   logic [POS_W-1:0]  issue_pos;
   logic [DATA_W-1:0] issue_seed;

   // Seed rotated left by (p mod DATA_W)
   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] s,
                                              input logic [POS_W-1:0]  p);
      logic [2*DATA_W-1:0] dbl;
      logic [POS_W-1:0]    sh;
      sh  = POS_W'(32'(p) % DATA_W);
      dbl = {s, s} << sh;
      return dbl[2*DATA_W-1:DATA_W];
   endfunction

   // Injector select for a vector; the last vector carries no error
   function automatic logic [SEL_W-1:0] sel_for(input logic [POS_W-1:0] p);
      if (32'(p) < NUM_POS) begin
         return SEL_W'(p);
      end
      return SEL_W'(NO_ERR_SEL);
   endfunction

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .tc_c  (tmr_tc_c)
   );

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pos         <= '0;
         seed        <= '0;
         expected    <= '0;
         enc_data_q  <= '0;
         enc_valid_q <= 1'b0;
         sel_q       <= SEL_W'(NO_ERR_SEL);
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_q       <= RESULT_CLEAR;
      end else begin
         state       <= state_nxt;
         pos         <= pos_nxt;
         seed        <= seed_nxt;
         expected    <= expected_nxt;
         enc_data_q  <= enc_data_nxt;
         enc_valid_q <= enc_valid_nxt;
         sel_q       <= sel_nxt;
         busy_q      <= busy_nxt;
         done_q      <= done_nxt;
         res_q       <= res_nxt;
      end
   end

   // Next state and next registered outputs. Outputs for a vector are
   // computed on the transition into ISSUE so they are valid during it.
   always_comb begin
      state_nxt     = state;
      pos_nxt       = pos;
      seed_nxt      = seed;
      expected_nxt  = expected;
      enc_data_nxt  = enc_data_q;
      enc_valid_nxt = 1'b0;
      sel_nxt       = sel_q;
      busy_nxt      = busy_q;
      done_nxt      = 1'b0;
      res_nxt       = res_q;
      tmr_clr       = 1'b0;
      tmr_en        = 1'b0;
      issue         = 1'b0;
      vec_end       = 1'b0;
      vec_fail      = 1'b0;
      issue_pos     = pos;
      issue_seed    = seed;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               seed_nxt   = data_seed;
               pos_nxt    = '0;
               res_nxt    = RESULT_CLEAR;
               issue      = 1'b1;
               issue_pos  = '0;
               issue_seed = data_seed;
               state_nxt  = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            tmr_clr   = 1'b1;
            state_nxt = ST_WAIT;
         end

         ST_WAIT: begin
            tmr_en = 1'b1;
            // A response on the terminal cycle still counts as a response
            if (bus.dec_valid) begin
               vec_end  = 1'b1;
               vec_fail = (bus.dec_data != expected);
            end else if (tmr_tc_c) begin
               vec_end             = 1'b1;
               vec_fail            = 1'b1;
               res_nxt.timeout_err = 1'b1;
            end

            if (vec_fail) begin
               res_nxt.fail_cnt = POS_W'(res_q.fail_cnt + 1'b1);
               if (res_q.first_fail_pos == FIRST_FAIL_NONE) begin
                  res_nxt.first_fail_pos = pos;
               end
            end

            if (vec_end) begin
               if (pos == POS_W'(NUM_POS)) begin
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
                  sel_nxt   = SEL_W'(NO_ERR_SEL);
               end else begin
                  pos_nxt   = POS_W'(pos + 1'b1);
                  issue     = 1'b1;
                  issue_pos = POS_W'(pos + 1'b1);
                  state_nxt = ST_ISSUE;
               end
            end
         end

         ST_DONE: begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Load the vector presented during the coming ISSUE cycle
      if (issue) begin
         enc_valid_nxt = 1'b1;
         busy_nxt      = 1'b1;
         enc_data_nxt  = rotl(issue_seed, issue_pos);
         expected_nxt  = rotl(issue_seed, issue_pos);
         sel_nxt       = sel_for(issue_pos);
      end
   end

   assign bus.enc_data    = enc_data_q;
   assign bus.enc_valid   = enc_valid_q;
   assign bus.selectt     = sel_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign fail_cnt        = res_q.fail_cnt;
   assign first_fail_pos  = res_q.first_fail_pos;
   assign timeout_err     = res_q.timeout_err;

endmodule

// File: tb/tb_error_sweep_ctrl.sv
// Bench for error_sweep_ctrl: a decoder model answers each vector one cycle
// after enc_valid, optionally corrupting, dropping or adding stray strobes.
module tb_error_sweep_ctrl;

   localparam int unsigned DATA_W  = 64;
   localparam int unsigned SEL_W   = 64;
   localparam int unsigned NUM_POS = 64;
   localparam int unsigned TIMEOUT = 16;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [DATA_W-1:0] data_seed;
   logic              busy;
   logic              done;
   logic [6:0]        fail_cnt;
   logic [6:0]        first_fail_pos;
   logic              timeout_err;

   int checks;
   int errors;

   typedef struct {
      logic [63:0] seed;
      int          corrupt_a;
      int          corrupt_b;
      int          drop;
      bit          noise;
      int          restart;
      int          exp_fail;
      int          exp_ffp;
      bit          exp_to;
      int          exp_cyc;
   } vec_t;

   vec_t tbl [7];

   error_sweep_ctrl_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

   error_sweep_ctrl #(
      .DATA_W  (DATA_W),
      .SEL_W   (SEL_W),
      .NUM_POS (NUM_POS),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .data_seed      (data_seed),
      .bus            (bus),
      .busy           (busy),
      .done           (done),
      .fail_cnt       (fail_cnt),
      .first_fail_pos (first_fail_pos),
      .timeout_err    (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] rotl_m(input logic [63:0] s, input int sh);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[(i + sh) % 64] = s[i];
      return r;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_enc_valid"}, 64'(bus.enc_valid), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
      chk({tag, "_enc_data"}, bus.enc_data, 64'd0);
      chk({tag, "_selectt"}, bus.selectt, 64'hFFFF_FFFF_FFFF_FFFF);
      chk({tag, "_fail_cnt"}, 64'(fail_cnt), 64'd0);
      chk({tag, "_first_fail_pos"}, 64'(first_fail_pos), 64'h7F);
   endtask

   // Run one full sweep for table entry t; called #1 after a clock edge.
   task automatic run_sweep(input int t);
      vec_t        v;
      int          vidx;
      int          restart_left;
      int          done_cyc;
      bit          pend;
      bit          prev_resp;
      logic [63:0] pdata;
      logic [63:0] last_sel;
      logic [63:0] exp_sel;
      v            = tbl[t];
      vidx         = -1;
      restart_left = 0;
      done_cyc     = -1;
      pend         = 1'b0;
      prev_resp    = v.noise;
      pdata        = '0;
      last_sel     = '1;
      data_seed    = v.seed;
      bus.dec_valid = v.noise;
      bus.dec_data  = 64'h5555_AAAA_5555_AAAA;
      start        = 1'b1;
      for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
         @(posedge clk);
         #1;
         start = (restart_left > 0);
         if (restart_left > 0) restart_left--;
         if (pend) begin
            bus.dec_valid = (vidx != v.drop);
            bus.dec_data  = pdata ^ ((vidx == v.corrupt_a || vidx == v.corrupt_b) ? 64'd1 : 64'd0);
            prev_resp     = (vidx != v.drop);
         end else if (v.noise && prev_resp) begin
            bus.dec_valid = 1'b1;
            bus.dec_data  = ~pdata;
            prev_resp     = 1'b0;
         end else begin
            bus.dec_valid = 1'b0;
            prev_resp     = 1'b0;
         end
         pend = 1'b0;

         if (bus.enc_valid) begin
            vidx++;
            if (vidx == 0) chk($sformatf("t%0d_first_issue_cycle", t), 64'(cyc), 64'd1);
            exp_sel = (vidx < int'(NUM_POS)) ? 64'(vidx) : 64'hFFFF_FFFF_FFFF_FFFF;
            chk($sformatf("t%0d_selectt_v%0d", t, vidx), bus.selectt, exp_sel);
            chk($sformatf("t%0d_enc_data_v%0d", t, vidx), bus.enc_data, rotl_m(v.seed, vidx % 64));
            chk($sformatf("t%0d_busy_v%0d", t, vidx), 64'(busy), 64'd1);
            last_sel = exp_sel;
            pend     = 1'b1;
            pdata    = bus.enc_data;
            if (vidx == v.restart) begin
               start        = 1'b1;
               restart_left = 2;
            end
         end else if (done) begin
            done_cyc = cyc;
            chk($sformatf("t%0d_done_selectt", t), bus.selectt, 64'hFFFF_FFFF_FFFF_FFFF);
            chk($sformatf("t%0d_done_busy", t), 64'(busy), 64'd1);
         end else begin
            chk($sformatf("t%0d_selectt_hold_v%0d", t, vidx), bus.selectt, last_sel);
         end
      end
      chk($sformatf("t%0d_done_cycle", t), 64'(done_cyc), 64'(v.exp_cyc));
      chk($sformatf("t%0d_vector_count", t), 64'(vidx + 1), 64'(NUM_POS + 1));

      @(posedge clk);
      #1;
      start         = 1'b0;
      bus.dec_valid = 1'b0;
      chk($sformatf("t%0d_done_one_cycle", t), 64'(done), 64'd0);
      chk($sformatf("t%0d_idle_busy", t), 64'(busy), 64'd0);
      chk($sformatf("t%0d_idle_selectt", t), bus.selectt, 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("t%0d_fail_cnt", t), 64'(fail_cnt), 64'(v.exp_fail));
      chk($sformatf("t%0d_first_fail_pos", t), 64'(first_fail_pos), 64'(v.exp_ffp));
      chk($sformatf("t%0d_timeout_err", t), 64'(timeout_err), 64'(v.exp_to));
   endtask

   // Reset asserted in the WAIT cycle of vector 30 of a partly failing sweep.
   task automatic reset_mid_sweep();
      int          vidx;
      bit          pend;
      bit          hit;
      logic [63:0] pdata;
      vidx      = -1;
      pend      = 1'b0;
      hit       = 1'b0;
      pdata     = '0;
      data_seed = 64'hFEDC_BA98_7654_3210;
      start     = 1'b1;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (pend) begin
            bus.dec_valid = 1'b1;
            bus.dec_data  = pdata ^ ((vidx == 2) ? 64'd1 : 64'd0);
         end else begin
            bus.dec_valid = 1'b0;
         end
         pend = 1'b0;
         if (bus.enc_valid) begin
            vidx++;
            pend  = 1'b1;
            pdata = bus.enc_data;
         end else if (vidx == 30) begin
            hit = 1'b1;
         end
      end
      chk("rst_reached_v30_wait", 64'(hit), 64'd1);
      chk("rst_pre_fail_cnt", 64'(fail_cnt), 64'd1);
      chk("rst_pre_busy", 64'(busy), 64'd1);
      chk("rst_pre_selectt", bus.selectt, 64'd30);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("rst_mid");
      bus.dec_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst_hold_done_%0d", i), 64'(done), 64'd0);
         chk($sformatf("rst_hold_busy_%0d", i), 64'(busy), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      start         = 1'b0;
      data_seed     = '0;
      bus.dec_valid = 1'b0;
      bus.dec_data  = '0;

      //           seed                   corA corB drop noise rst  fail ffp  to    cyc
      tbl[0] = '{64'h0123_4567_89AB_CDEF,  -1,  -1,  -1, 1'b0, -1,  0, 127, 1'b0, 131};
      tbl[1] = '{64'h0123_4567_89AB_CDEF,  17,  40,  -1, 1'b0, -1,  2,  17, 1'b0, 131};
      tbl[2] = '{64'h0123_4567_89AB_CDEF,  -1,  -1,   5, 1'b0, -1,  1,   5, 1'b1, 146};
      tbl[3] = '{64'hFFFF_0000_A5A5_0001,   0,  64,  -1, 1'b0, -1,  2,   0, 1'b0, 131};
      tbl[4] = '{64'h8000_0000_0000_0001,   3,  -1,  64, 1'b0, -1,  2,   3, 1'b1, 146};
      tbl[5] = '{64'h0123_4567_89AB_CDEF,  -1,  -1,  -1, 1'b1, -1,  0, 127, 1'b0, 131};
      tbl[6] = '{64'h0123_4567_89AB_CDEF,  17,  -1,  -1, 1'b0, 10,  1,  17, 1'b0, 131};

      #12;
      check_reset("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_reset("post_release");

      for (int t = 0; t < 7; t++) run_sweep(t);

      // Stray decoder strobes while idle must leave the results alone
      for (int i = 0; i < 4; i++) begin
         bus.dec_valid = 1'b1;
         bus.dec_data  = 64'hDEAD_BEEF_0000_0000 | 64'(i);
         @(posedge clk);
         #1;
      end
      bus.dec_valid = 1'b0;
      chk("idle_decv_fail_cnt", 64'(fail_cnt), 64'd1);
      chk("idle_decv_first_fail_pos", 64'(first_fail_pos), 64'd17);
      chk("idle_decv_busy", 64'(busy), 64'd0);
      chk("idle_decv_enc_valid", 64'(bus.enc_valid), 64'd0);

      reset_mid_sweep();
      run_sweep(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
